// File: rtl/fsb_ram_arb.sv
// rtl/fsb_ram_arb.sv - FSB local-RAM access arbiter with periodic refresh
module fsb_ram_arb #(
    parameter logic [3:0] RAM_BASE     = 4'h4, // FSB_A[31:28] value that selects local RAM
    parameter int         WS           = 2,    // wait cycles in ACCESS (0..15)
    parameter int         REF_INTERVAL = 780,  // refresh period in FSBCLK cycles (>= 16)
    parameter int         REF_LEN      = 4     // RAM_nREF low time in cycles (1..15)
) (
    input  logic        FSBCLK,     // single clock, rising edge
    input  logic        RESET,      // synchronous, active high
    input  logic        CPU_nAS,    // CPU address strobe, active low
    input  logic        CPU_RnW,    // 1 = read, 0 = write
    input  logic [31:0] FSB_A,      // FSB address
    output logic [23:0] RAM_A,      // latched FSB_A[25:2]
    output logic        RAM_nCS,    // RAM select, active low
    output logic        RAM_nWE,    // RAM write enable, active low
    output logic        RAM_nREF,   // RAM refresh strobe, active low
    output logic        CPU_nSTERM, // synchronous cycle termination, active low
    output logic        BUSY        // state is not IDLE
);

    localparam int               REF_W    = $clog2(REF_INTERVAL);
    localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REF_INTERVAL - 1);
    localparam logic [3:0]       WS_LOAD  = 4'(WS);
    localparam logic [3:0]       LEN_LOAD = 4'(REF_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        TERM,
        WAITAS,
        REFRESH
    } state_t;

    state_t           state;
    logic [REF_W-1:0] ref_cnt;
    logic             ref_pend;
    logic [3:0]       wait_cnt;
    logic [3:0]       len_cnt;
    logic             cpu_req;
    logic             ref_tick;
    logic             unused_fsb_a;

    assign cpu_req      = !CPU_nAS && (FSB_A[31:28] == RAM_BASE);
    assign ref_tick     = (ref_cnt == '0);
    assign BUSY         = (state != IDLE);
    assign unused_fsb_a = ^{FSB_A[27:26], FSB_A[1:0]};

    always_ff @(posedge FSBCLK) begin
        if (RESET) begin
            state      <= IDLE;
            RAM_A      <= '0;
            RAM_nCS    <= 1'b1;
            RAM_nWE    <= 1'b1;
            RAM_nREF   <= 1'b1;
            CPU_nSTERM <= 1'b1;
            ref_cnt    <= REF_LOAD;
            ref_pend   <= 1'b0;
            wait_cnt   <= '0;
            len_cnt    <= '0;
        end else begin
            // Free-running refresh timer; a pending request is never queued twice.
            if (ref_tick) begin
                ref_cnt  <= REF_LOAD;
                ref_pend <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ref_pend) begin
                        // Refresh beats the CPU; the CPU request is simply re-sampled later.
                        state    <= REFRESH;
                        ref_pend <= ref_tick;
                        len_cnt  <= LEN_LOAD;
                        RAM_nREF <= 1'b0;
                    end else if (cpu_req) begin
                        state    <= ACCESS;
                        RAM_A    <= FSB_A[25:2];
                        RAM_nWE  <= CPU_RnW;
                        RAM_nCS  <= 1'b0;
                        wait_cnt <= WS_LOAD;
                    end
                end
                ACCESS: begin
                    if (CPU_nAS) begin
                        // CPU abandoned the cycle: drop the RAM without terminating.
                        state   <= IDLE;
                        RAM_nCS <= 1'b1;
                        RAM_nWE <= 1'b1;
                    end else if (wait_cnt == '0) begin
                        state      <= TERM;
                        CPU_nSTERM <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                TERM: begin
                    state      <= WAITAS;
                    RAM_nCS    <= 1'b1;
                    RAM_nWE    <= 1'b1;
                    CPU_nSTERM <= 1'b1;
                end
                WAITAS: begin
                    // Hold off until the strobe is released so one strobe means one access.
                    if (CPU_nAS) begin
                        state <= IDLE;
                    end
                end
                REFRESH: begin
                    if (len_cnt == '0) begin
                        state    <= IDLE;
                        RAM_nREF <= 1'b1;
                    end else begin
                        len_cnt <= len_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsb_ram_arb.sv
// tb/tb_fsb_ram_arb.sv - self-checking bench for fsb_ram_arb
module tb_fsb_ram_arb;

    logic              clk = 1'b0;
    logic              rst;
    logic              nas;
    logic              rnw;
    logic [31:0]       addr;
    logic [2:0]        ncs;
    logic [2:0]        nwe;
    logic [2:0]        nref;
    logic [2:0]        nst;
    logic [2:0]        busy;
    logic [2:0][23:0]  ram_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: WS=2, 1: WS=3, 2: WS=0 with short refresh period
    fsb_ram_arb #(.RAM_BASE(4'h4), .WS(2), .REF_INTERVAL(200), .REF_LEN(4)) u_a (
        .FSBCLK(clk), .RESET(rst), .CPU_nAS(nas), .CPU_RnW(rnw), .FSB_A(addr),
        .RAM_A(ram_a[0]), .RAM_nCS(ncs[0]), .RAM_nWE(nwe[0]), .RAM_nREF(nref[0]),
        .CPU_nSTERM(nst[0]), .BUSY(busy[0]));

    fsb_ram_arb #(.RAM_BASE(4'h4), .WS(3), .REF_INTERVAL(200), .REF_LEN(4)) u_c (
        .FSBCLK(clk), .RESET(rst), .CPU_nAS(nas), .CPU_RnW(rnw), .FSB_A(addr),
        .RAM_A(ram_a[1]), .RAM_nCS(ncs[1]), .RAM_nWE(nwe[1]), .RAM_nREF(nref[1]),
        .CPU_nSTERM(nst[1]), .BUSY(busy[1]));

    fsb_ram_arb #(.RAM_BASE(4'h4), .WS(0), .REF_INTERVAL(16), .REF_LEN(4)) u_r (
        .FSBCLK(clk), .RESET(rst), .CPU_nAS(nas), .CPU_RnW(rnw), .FSB_A(addr),
        .RAM_A(ram_a[2]), .RAM_nCS(ncs[2]), .RAM_nWE(nwe[2]), .RAM_nREF(nref[2]),
        .CPU_nSTERM(nst[2]), .BUSY(busy[2]));

    typedef struct {
        logic        rst;
        logic        nas;
        logic        rnw;
        logic [31:0] addr;
        int          d;
        logic        ncs;
        logic        nwe;
        logic        nref;
        logic        nst;
        logic        busy;
        logic [23:0] a;
    } vec_t;

    vec_t v[$];

    localparam logic [31:0] A_RD  = 32'h4000_1234;
    localparam logic [31:0] A_WR  = 32'h4000_0010;
    localparam logic [31:0] A_COL = 32'h4000_0020;
    localparam logic [31:0] A_AB  = 32'h4000_0100;
    localparam logic [31:0] A_OFF = 32'h5000_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic n, input logic w, input logic [31:0] a_in,
                       input int d, input logic e_ncs, input logic e_nwe, input logic e_nref,
                       input logic e_nst, input logic e_busy, input logic [23:0] e_a);
        vec_t e;
        e.rst = r; e.nas = n; e.rnw = w; e.addr = a_in; e.d = d;
        e.ncs = e_ncs; e.nwe = e_nwe; e.nref = e_nref; e.nst = e_nst; e.busy = e_busy; e.a = e_a;
        v.push_back(e);
    endtask

    task automatic tick(input logic r, input logic n, input logic w, input logic [31:0] a_in);
        rst = r; nas = n; rnw = w; addr = a_in;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ref(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 1'b1, 1'b1, 32'h0);
            if (nref[2] === 1'b0) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;

        // Read, WS=2
        add(1,1,1,32'h0, 0, 1,1,1,1,0, 24'h0);
        add(0,0,1,A_RD,  0, 0,1,1,1,1, 24'h00048D);
        add(0,0,1,A_RD,  0, 0,1,1,1,1, 24'h00048D);
        add(0,0,1,A_RD,  0, 0,1,1,1,1, 24'h00048D);
        add(0,0,1,A_RD,  0, 0,1,1,0,1, 24'h00048D);
        add(0,0,1,A_RD,  0, 1,1,1,1,1, 24'h00048D);
        add(0,0,1,A_RD,  0, 1,1,1,1,1, 24'h00048D);
        add(0,1,1,A_RD,  0, 1,1,1,1,0, 24'h00048D);
        add(0,1,1,32'h0, 0, 1,1,1,1,0, 24'h00048D);

        // Write, WS=0, strobe low for 10 cycles, then refresh/CPU collision
        add(1,1,1,32'h0, 2, 1,1,1,1,0, 24'h0);
        add(0,0,0,A_WR,  2, 0,0,1,1,1, 24'h4);
        add(0,0,0,A_WR,  2, 0,0,1,0,1, 24'h4);
        for (int i = 0; i < 8; i++) add(0,0,0,A_WR, 2, 1,1,1,1,1, 24'h4);
        add(0,1,0,A_WR,  2, 1,1,1,1,0, 24'h4);
        for (int i = 0; i < 5; i++) add(0,1,1,32'h0, 2, 1,1,1,1,0, 24'h4);
        for (int i = 0; i < 4; i++) add(0,0,1,A_COL, 2, 1,1,0,1,1, 24'h4);
        add(0,0,1,A_COL, 2, 1,1,1,1,0, 24'h4);
        add(0,0,1,A_COL, 2, 0,1,1,1,1, 24'h8);
        add(0,0,1,A_COL, 2, 0,1,1,0,1, 24'h8);
        add(0,0,1,A_COL, 2, 1,1,1,1,1, 24'h8);
        add(0,1,1,A_COL, 2, 1,1,1,1,0, 24'h8);

        // Abort one cycle into ACCESS, WS=3
        add(1,1,1,32'h0, 1, 1,1,1,1,0, 24'h0);
        add(0,0,1,A_AB,  1, 0,1,1,1,1, 24'h40);
        for (int i = 0; i < 3; i++) add(0,1,1,A_AB, 1, 1,1,1,1,0, 24'h40);

        // Non-matching address with strobe held low
        add(1,1,1,32'h0, 0, 1,1,1,1,0, 24'h0);
        for (int i = 0; i < 20; i++) add(0,0,1,A_OFF, 0, 1,1,1,1,0, 24'h0);

        foreach (v[i]) begin
            tick(v[i].rst, v[i].nas, v[i].rnw, v[i].addr);
            chk($sformatf("v%0d/ncs", i),   {31'b0, ncs[v[i].d]},  {31'b0, v[i].ncs});
            chk($sformatf("v%0d/nwe", i),   {31'b0, nwe[v[i].d]},  {31'b0, v[i].nwe});
            chk($sformatf("v%0d/nref", i),  {31'b0, nref[v[i].d]}, {31'b0, v[i].nref});
            chk($sformatf("v%0d/nsterm", i),{31'b0, nst[v[i].d]},  {31'b0, v[i].nst});
            chk($sformatf("v%0d/busy", i),  {31'b0, busy[v[i].d]}, {31'b0, v[i].busy});
            chk($sformatf("v%0d/ram_a", i), {8'b0, ram_a[v[i].d]}, {8'b0, v[i].a});
        end

        // Reset during TERM of a write (WS=2)
        tick(1'b1, 1'b1, 1'b1, 32'h0);
        tick(1'b0, 1'b0, 1'b0, A_WR);
        tick(1'b0, 1'b0, 1'b0, A_WR);
        tick(1'b0, 1'b0, 1'b0, A_WR);
        tick(1'b0, 1'b0, 1'b0, A_WR);
        chk("term/nsterm", {31'b0, nst[0]}, 32'd0);
        chk("term/nwe",    {31'b0, nwe[0]}, 32'd0);
        tick(1'b1, 1'b1, 1'b1, A_WR);
        chk("rst_term/ncs",    {31'b0, ncs[0]},  32'd1);
        chk("rst_term/nwe",    {31'b0, nwe[0]},  32'd1);
        chk("rst_term/nsterm", {31'b0, nst[0]},  32'd1);
        chk("rst_term/busy",   {31'b0, busy[0]}, 32'd0);
        chk("rst_term/ram_a",  {8'b0, ram_a[0]}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, A_WR);
            chk($sformatf("post_rst%0d/nsterm", i), {31'b0, nst[0]},  32'd1);
            chk($sformatf("post_rst%0d/busy", i),   {31'b0, busy[0]}, 32'd0);
        end

        // Refresh timing from reset, and reset during REFRESH (REF_INTERVAL=16)
        tick(1'b1, 1'b1, 1'b1, 32'h0);
        wait_ref(k);
        chk("first_ref_edge", k, 32'd17);
        tick(1'b0, 1'b1, 1'b1, 32'h0);
        chk("mid_ref/nref", {31'b0, nref[2]}, 32'd0);
        chk("mid_ref/busy", {31'b0, busy[2]}, 32'd1);
        tick(1'b1, 1'b1, 1'b1, 32'h0);
        chk("rst_ref/nref",   {31'b0, nref[2]}, 32'd1);
        chk("rst_ref/busy",   {31'b0, busy[2]}, 32'd0);
        chk("rst_ref/ncs",    {31'b0, ncs[2]},  32'd1);
        chk("rst_ref/nsterm", {31'b0, nst[2]},  32'd1);
        wait_ref(k);
        chk("ref_after_rst_edge", k, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsb_ram_arb.md
FSB_RAM_ARB -- requirements
Module: fsb_ram_arb

Interface
REQ-001 SHALL have parameter RAM_BASE, default 4'h4, the value of FSB_A[31:28] that selects local RAM.
REQ-002 SHALL have parameter WS, default 2, the number of wait cycles in ACCESS (legal range 0..15).
REQ-003 SHALL have parameter REF_INTERVAL, default 780, the refresh period in FSBCLK cycles (legal range ≥ 16).
REQ-004 SHALL have parameter REF_LEN, default 4, the number of cycles RAM_nREF is held low (legal range 1..15).
REQ-005 SHALL have port FSBCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port CPU_nAS, input, 1 bit: CPU address strobe, active low.
REQ-008 SHALL have port CPU_RnW, input, 1 bit: 1 = read, 0 = write.
REQ-009 SHALL have port FSB_A, input, 32 bits: FSB address.
REQ-010 SHALL have port RAM_A, output, 24 bits: latched FSB_A[25:2].
REQ-011 SHALL have port RAM_nCS, output, 1 bit: RAM select, active low.
REQ-012 SHALL have port RAM_nWE, output, 1 bit: RAM write enable, active low.
REQ-013 SHALL have port RAM_nREF, output, 1 bit: RAM refresh strobe, active low.
REQ-014 SHALL have port CPU_nSTERM, output, 1 bit: synchronous cycle termination, active low.
REQ-015 SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, ACCESS, TERM, WAITAS and REFRESH; all outputs SHALL be registered or decoded from registered state only.
REQ-017 SHALL define CPU request as: CPU_nAS==0 and FSB_A[31:28]==RAM_BASE, sampled at the FSBCLK edge.
REQ-018 SHALL run a refresh down-counter that loads REF_INTERVAL-1 and decrements every cycle in every state.
- At 0 it SHALL set ref_pend and reload.
- If ref_pend is already set, it SHALL stay set; there is no queueing of a second request.
REQ-019 IDLE arbitration: ref_pend=1 SHALL win over a simultaneous CPU request.
- Refresh wins: go to REFRESH.
- Otherwise, CPU request: go to ACCESS, latching RAM_A<=FSB_A[25:2] and the write flag <= ~CPU_RnW at that edge.
- Otherwise: stay in IDLE.
REQ-020 A losing CPU request SHALL not be recorded; it is re-sampled in IDLE because CPU_nAS remains low.
REQ-021 ACCESS: RAM_nCS=0, and RAM_nWE=0 only for a latched write.
- The wait counter SHALL load WS on entry; ACCESS SHALL last WS+1 cycles.
- Then go to TERM.
REQ-022 TERM SHALL last exactly 1 cycle with CPU_nSTERM=0 and RAM_nCS/RAM_nWE held as in ACCESS, then go to WAITAS.
REQ-023 Latency: request sampled at edge N → RAM_nCS low from edge N to edge N+WS+2 → CPU_nSTERM low from edge N+WS+1 to edge N+WS+2.
REQ-024 WAITAS: RAM_nCS=1 and CPU_nSTERM=1; go to IDLE on the first edge where CPU_nAS==1. A continuously low CPU_nAS SHALL never cause a second access.
REQ-025 Abort: CPU_nAS==1 sampled in ACCESS SHALL go directly to IDLE with no CPU_nSTERM pulse; RAM_nCS SHALL deassert at that edge.
REQ-026 REFRESH: RAM_nREF=0 for exactly REF_LEN cycles, with ref_pend cleared on entry, then go to IDLE. CPU requests during REFRESH SHALL be ignored.
REQ-027 Non-matching addresses SHALL produce no RAM or STERM activity in any state.
REQ-028 RAM_A SHALL hold its value outside ACCESS and TERM.
REQ-029 Counters SHALL not wrap:
- The wait counter saturates at 0.
- The refresh length counter stops at 0.

Reset
REQ-030 On RESET=1 at an edge, the block SHALL go to IDLE with:
- RAM_nCS=1, RAM_nWE=1, RAM_nREF=1, CPU_nSTERM=1, BUSY=0
- RAM_A=0, ref_pend=0
- refresh counter loaded with REF_INTERVAL-1
- wait and refresh length counters set to 0
REQ-031 RESET SHALL take priority over every transition, including mid-ACCESS and mid-REFRESH. Outputs SHALL reach their reset values in the same cycle, and no STERM SHALL follow.
REQ-032 After RESET is released, the first refresh request SHALL occur REF_INTERVAL cycles later.

Verification
REQ-033 Read, WS=2: CPU_nAS=0, FSB_A=32'h4000_1234, CPU_RnW=1 at edge N.
- RAM_A=24'h00048D.
- RAM_nCS low over edges N..N+4, RAM_nWE=1.
- CPU_nSTERM low for 1 cycle from edge N+3.
- Return to IDLE one edge after CPU_nAS rises.
REQ-034 Write, WS=0, CPU_nAS held low for 10 cycles.
- RAM_nWE low for 2 cycles and exactly one CPU_nSTERM pulse.
- No second access.
REQ-035 Collision, REF_INTERVAL=16: assert a CPU request in the same cycle that ref_pend is set.
- RAM_nREF low for 4 cycles first.
- ACCESS starts on the next edge after REFRESH ends.
REQ-036 Abort: CPU_nAS rises 1 cycle into ACCESS (WS=3).
- Returns to IDLE.
- CPU_nSTERM is never low; RAM_nCS goes high on the same edge.
REQ-037 Decode: FSB_A=32'h5000_0000 with CPU_nAS low for 20 cycles → RAM_nCS=1, CPU_nSTERM=1 and BUSY=0 throughout, except while refreshing.
REQ-038 Reset mid-cycle: RESET=1 during TERM or REFRESH.
- All outputs take their reset values at the next edge.
- The next RAM_nREF pulse occurs REF_INTERVAL cycles after release.
